// File: rtl/aes_axis_pkg.sv
// Shared definitions for the AES AXI4-Stream input/output adapters.
//   - default block and stream widths plus the derived word counts
//   - lane_byte_idx(): which block byte lands on a given stream word/lane
//   - tx_state_e: output serializer FSM states
package aes_axis_pkg;

  localparam int BLK_S_DEF     = 128;
  localparam int DATA_W_DEF    = 32;
  localparam int WORDS_PER_BLK = BLK_S_DEF / DATA_W_DEF;
  localparam int LAST_WORD     = WORDS_PER_BLK - 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

  // Little-endian lanes: lane j of word k carries block byte (DATA_W/8)*k + j.
  // The input deserializer uses the same mapping, so a block survives a
  // round trip through both adapters unchanged.
  function automatic int lane_byte_idx(input int word, input int lane, input int data_w);
    return (data_w / 8) * word + lane;
  endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Block buffer between the AES core result and the stream serializer.
//   clk, reset     : single clock, synchronous active-high reset
//   push, wr_data  : write an entry (ignored when full)
//   pop            : retire the head entry (ignored when empty)
//   rd_data        : head entry, valid whenever !empty
//   full, empty    : occupancy flags derived from the registered count
//   count_next     : occupancy after the current edge, used by the FSM to
//                    enter/leave SEND without a bubble
module aes_blk_fifo #(
  parameter int W     = 129,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wr_data,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count_next
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full       = (count == CNT_W'(DEPTH));
    empty      = (count == '0);
    do_push    = push && !full;
    do_pop     = pop && !empty;
    count_next = count + CNT_W'(do_push) - CNT_W'(do_pop);
    rd_data    = mem[rd_ptr];
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

  // Storage is not cleared; entries are only visible through valid pointers.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/aes_axis_tx.sv
// Output serializer of the AES AXI4-Stream accelerator.
// Takes one 128-bit result block per aes_done strobe, buffers up to
// BUF_DEPTH blocks and emits each as BLK_S/DATA_W stream words.
//   clk, reset        : single clock, synchronous active-high reset
//   blk_data          : result block, byte 0 = blk_data[0:7]
//   blk_valid         : one-cycle strobe, blk_data/blk_last valid
//   blk_last          : block ends a packet (tlast on its final word)
//   blk_ready         : buffer can take a block this cycle
//   m_axis_*          : AXI4-Stream master
//   overflow          : sticky, a block arrived while blk_ready was 0
//   busy              : buffer holds at least one block
//   dbg_state         : current serializer FSM state
//
// Handshake: a stream word transfers on a rising edge where tvalid and tready
// are both 1. Once tvalid is raised it stays up, with tdata/tlast unchanged,
// until that transfer happens (only reset can drop it). A block is taken on a
// rising edge where blk_valid and blk_ready are both 1; blk_valid with
// blk_ready low drops the block and sets overflow.
module aes_axis_tx
  import aes_axis_pkg::*;
#(
  parameter int BLK_S     = BLK_S_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BUF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [0:BLK_S-1]     blk_data,
  input  logic                 blk_valid,
  input  logic                 blk_last,
  output logic                 blk_ready,
  output logic [DATA_W-1:0]    m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 overflow,
  output logic                 busy,
  output tx_state_e            dbg_state
);

  localparam int N_WORDS  = BLK_S / DATA_W;
  localparam int LAST_IDX = N_WORDS - 1;
  localparam int IDX_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int CNT_W    = $clog2(BUF_DEPTH) + 1;
  localparam int ENTRY_W  = BLK_S + 1;

  tx_state_e          state;
  tx_state_e          state_next;
  logic [IDX_W-1:0]   word_idx;
  logic               ready_en;
  logic               push;
  logic               pop;
  logic               on_last_word;
  logic [ENTRY_W-1:0] head;
  logic [0:BLK_S-1]   head_data;
  logic               head_last;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   count_next;
  logic [DATA_W-1:0]  lane_data;

  // ready_en keeps blk_ready low for the cycle right after reset.
  assign blk_ready    = ready_en && !fifo_full;
  assign push         = blk_valid && blk_ready;
  assign on_last_word = (word_idx == IDX_W'(LAST_IDX));
  assign pop          = (state == SEND) && m_axis_tready && on_last_word;
  assign busy         = !fifo_empty;
  assign dbg_state    = state;

  // Entry layout: block in the upper bits (byte 0 at the top), last flag at bit 0.
  assign head_data = head[ENTRY_W-1:1];
  assign head_last = head[0];

  aes_blk_fifo #(
    .W     (ENTRY_W),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .wr_data    ({blk_data, blk_last}),
    .pop        (pop),
    .rd_data    (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count_next (count_next)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state. Looking at the post-edge count lets a block accepted at edge N
  // be on the bus in the very next cycle and lets back-to-back blocks stream
  // without an idle cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count_next != '0) state_next = SEND;
      SEND:    if (pop && count_next == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Word lane mux for the head block.
  always_comb begin
    lane_data = '0;
    for (int j = 0; j < DATA_W / 8; j++) begin
      lane_data[8*j +: 8] = head_data[8*lane_byte_idx(int'(word_idx), j, DATA_W) +: 8];
    end
  end

  // Outputs
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    if (state == SEND) begin
      m_axis_tvalid = 1'b1;
      m_axis_tdata  = lane_data;
      m_axis_tlast  = on_last_word && head_last;
    end
  end

  // Word index, overflow flag, ready enable
  always_ff @(posedge clk) begin
    if (reset) begin
      word_idx <= '0;
      overflow <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (blk_valid && !blk_ready) overflow <= 1'b1;
      if (state == SEND && m_axis_tready) begin
        if (on_last_word) word_idx <= '0;
        else              word_idx <= word_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: doc/aes_axis_tx.md
Name: aes_axis_tx

Overview:
Output-side serializer of the AES AXI4-Stream accelerator, the counterpart of the input deserializer that assembles plaintext/key words into blocks.
- Accepts one 128-bit result block from the AES core per `aes_done` pulse.
- Buffers up to BUF_DEPTH blocks.
- Emits each block as BLK_S/DATA_W words on an AXI4-Stream master port, with full tready backpressure.
- Sits between the AES core output and the output stream (downstream DMA S2MM).

Parameters:
BLK_S, 128, block width in bits; must be a multiple of DATA_W.
DATA_W, 32, AXI4-Stream tdata width; multiple of 8.
BUF_DEPTH, 2, number of result blocks buffered; power of two, at least 2.

Ports:
clk  input  1  single clock for all logic
reset  input  1  synchronous, active-high reset
blk_data  input  [0:BLK_S-1]  result block; byte 0 = blk_data[0:7]
blk_valid  input  1  one-cycle strobe (aes_done): blk_data/blk_last valid
blk_last  input  1  block ends a packet; drives tlast on its final word
blk_ready  output  1  buffer can accept a block this cycle
m_axis_tdata  output  DATA_W  stream data
m_axis_tvalid  output  1  stream valid
m_axis_tready  input  1  stream ready
m_axis_tlast  output  1  final word of a blk_last block
overflow  output  1  sticky: blk_valid seen while blk_ready=0
busy  output  1  buffer non-empty

Behaviour:
- Reset (synchronous, checked at posedge clk):
  - outputs: tvalid=0, tlast=0, tdata=0, overflow=0, busy=0, blk_ready=0.
  - clears the buffer, the word index and pointers.
  - blk_ready=1 from the first cycle after reset deasserts.
  - Reset mid-transfer discards all buffered blocks; no partial words are emitted afterwards.
- Input side:
  - blk_ready = !full (registered count).
  - Accept on posedge when blk_valid && blk_ready: write {blk_data, blk_last} at wr_ptr, increment wr_ptr modulo BUF_DEPTH.
  - blk_valid && !blk_ready: block dropped, overflow set to 1; overflow stays 1 until reset.
  - No combinational path from blk_valid to m_axis_*.
- Latency: block accepted at edge N into an empty buffer -> tvalid=1 with word 0 in the cycle after edge N.
- Word mapping: word k (k=0..BLK_S/DATA_W-1), lane j: tdata[8j+7:8j] = byte (DATA_W/8)*k + j of the block, i.e. little-endian lanes. This matches the input deserializer's ordering.
- Output FSM, 2 states:
  - IDLE: tvalid=0. Go to SEND when count>0.
  - SEND: tvalid=1; tdata = head block, word word_idx.
    - tlast=1 iff word_idx==LAST_WORD and the head entry's last flag is set.
    - On tvalid && tready:
      - word_idx < LAST_WORD: word_idx++.
      - word_idx == LAST_WORD: pop head (rd_ptr++), word_idx=0. Stay in SEND if count after the pop is >0 (no bubble between blocks), else go to IDLE.
- AXI rule: while tvalid && !tready, tdata and tlast are held stable; tvalid never drops without a handshake (except on reset).
- Simultaneous push and pop in the same cycle: count unchanged, both pointers advance. When the buffer is full at that edge, the push is rejected because blk_ready was 0 (no pass-through).
- Pointer wrap-around: modulo BUF_DEPTH; full when count==BUF_DEPTH, empty when count==0.
- busy = (count!=0).
- Throughput: one word per cycle with tready held high; back-to-back blocks add no idle cycles.

Decomposition:
- Package aes_axis_pkg: BLK_S/DATA_W defaults, WORDS_PER_BLK = BLK_S/DATA_W, LAST_WORD, the byte-lane select function shared with the input deserializer, and the state enum {IDLE, SEND}.
- Sub-module aes_blk_fifo: BUF_DEPTH x (BLK_S+1) storage, pointers, count, full/empty.
- Top module: FSM, word index, lane mux, overflow flag.

Test Plan:
- Key 5468617473206D79204B756E67204675 / plaintext 54776F204F6E65204E696E652054776F: core result 29C3505F571420F6402299B31A02D73A with blk_last=1, tready=1 -> 4 consecutive beats 0x5F50C329, 0xF6201457, 0xB3992240, 0x3AD7021A; tlast only on beat 4; tvalid rises 1 cycle after accept.
- Same block, tready oscillating 2 cycles low / 6 high -> identical word sequence; tdata/tlast stable during every low-tready cycle; no words lost or duplicated.
- 3 blocks pushed on consecutive cycles, tready=0 -> blocks 1 and 2 accepted, blk_ready=0 at block 3, overflow=1; after releasing tready -> exactly 8 beats, overflow still 1.
- Two blocks, blk_last=0 then 1, tready=1 -> 8 beats with no gap; tlast on beat 8 only; busy falls the cycle after beat 8.
- Reset asserted after beat 2 of a block -> next cycle tvalid=0, busy=0, overflow=0; a new block afterwards starts at word 0.
- Push into a full buffer on the same edge as the final-word pop -> push rejected (overflow=1), pop completes, blk_ready=1 on the next cycle.
